// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared constants, opcodes and state encoding for the mul/div sequencer
package md_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational shift-add (MUL) or restoring-division (DIV) iteration
module md_step
    import md_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opr,
    input  logic [WIDTH-1:0] opd,
    input  logic             div_mode,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] opr_next,
    output logic             q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // MUL: {acc,opr} is the product register, multiplier consumed LSB first.
    // DIV: acc is the partial remainder, opr shifts the dividend out MSB first.
    always_comb begin
        sum      = {1'b0, acc} + (opr[0] ? {1'b0, opd} : '0);
        shifted  = {acc, opr[WIDTH-1]};
        diff     = shifted - {1'b0, opd};
        q_bit    = 1'b0;
        acc_next = sum[WIDTH:1];
        opr_next = {sum[0], opr[WIDTH-1:1]};
        if (div_mode) begin
            q_bit    = ~diff[WIDTH];
            acc_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            opr_next = {opr[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - iterative 32-bit unsigned multiply/divide sequencer with flush and stall
module md_sequencer
    import md_pkg::*;
(
    input  logic             clock,
    input  logic             reset_0,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opr;
    logic [WIDTH-1:0] opd;

    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_opr;
    logic             step_q;
    logic [WIDTH-1:0] opr_iter;
    logic             op_valid;
    logic             can_accept;

    assign op_valid   = (op == ALU_MUL) || (op == ALU_DIV);
    assign can_accept = (state == ST_IDLE) || (state == ST_DONE);
    assign stall      = reset_0 && (busy || (start && op_valid && can_accept));
    assign opr_iter   = step_opr | {{(WIDTH-1){1'b0}}, step_q};

    md_step u_step (
        .acc      (acc),
        .opr      (opr),
        .opd      (opd),
        .div_mode (state == ST_DIV),
        .acc_next (step_acc),
        .opr_next (step_opr),
        .q_bit    (step_q)
    );

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            opr   <= '0;
            opd   <= '0;
            hi    <= '0;
            lo    <= '0;
            dz    <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (start && op_valid && !flush) begin
                        cnt <= CNT_W'(ITER - 1);
                        acc <= '0;
                        if (op == ALU_MUL) begin
                            state <= ST_MUL;
                            busy  <= 1'b1;
                            opr   <= b;
                            opd   <= a;
                        end else if (b == '0) begin
                            // Divide-by-zero resolves immediately without iterating
                            state <= ST_DONE;
                            done  <= 1'b1;
                            hi    <= a;
                            lo    <= '1;
                            dz    <= 1'b1;
                        end else begin
                            state <= ST_DIV;
                            busy  <= 1'b1;
                            opr   <= a;
                            opd   <= b;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= step_acc;
                        opr <= opr_iter;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            hi    <= step_acc;
                            lo    <= opr_iter;
                            dz    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - randomized self-checking bench for md_sequencer against an arithmetic model
module tb_md_sequencer;

    logic        clock;
    logic        reset_0;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int n_pass;
    int n_total;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_cyc;

    md_sequencer dut (
        .clock   (clock),
        .reset_0 (reset_0),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dz      (dz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model(input logic [3:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b);
        logic [63:0] prod;
        if (m_op == 4'b1000) begin
            prod    = 64'(m_a) * 64'(m_b);
            exp_hi  = prod[63:32];
            exp_lo  = prod[31:0];
            exp_dz  = 1'b0;
            exp_cyc = 33;
        end else if (m_b == 32'd0) begin
            exp_hi  = m_a;
            exp_lo  = 32'hFFFF_FFFF;
            exp_dz  = 1'b1;
            exp_cyc = 1;
        end else begin
            exp_hi  = m_a % m_b;
            exp_lo  = m_a / m_b;
            exp_dz  = 1'b0;
            exp_cyc = 33;
        end
    endtask

    // Caller is positioned mid-cycle (after a negedge); returns the stall seen in cycle 0.
    task automatic start_op(input logic [3:0] s_op, input logic [31:0] s_a,
                            input logic [31:0] s_b, output logic stall0);
        start = 1'b1;
        op    = s_op;
        a     = s_a;
        b     = s_b;
        #1 stall0 = stall;
        @(posedge clock);
        #1 start = 1'b0;
        op = 4'd0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int cyc);
        n_total++;
        if (cyc !== exp_cyc) $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
        else n_pass++;
        n_total++;
        if (hi !== exp_hi) $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi);
        else n_pass++;
        n_total++;
        if (lo !== exp_lo) $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo);
        else n_pass++;
        n_total++;
        if (dz !== exp_dz) $display("FAIL %s dz: got %b expected %b", name, dz, exp_dz);
        else n_pass++;
    endtask

    task automatic check_quiet(input string name, input int ncyc);
        int seen;
        seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL %s quiet: got %0d active cycles expected 0", name, seen);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_0 = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_total++;
        if ({hi, lo, dz, done, busy, stall} !== 68'd0)
            $display("FAIL reset_state: got hi=%h lo=%h dz=%b done=%b busy=%b stall=%b expected all 0",
                     hi, lo, dz, done, busy, stall);
        else n_pass++;
        reset_0 = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        exp_dz = 1'b0;
    endtask

    task automatic test_mul_basic();
        logic s0;
        int   bad;
        @(negedge clock);
        model(4'b1000, 32'd7, 32'd6);
        start_op(4'b1000, 32'd7, 32'd6, s0);
        n_total++;
        if (s0 !== 1'b1) $display("FAIL mul_stall_c0: got %b expected 1", s0);
        else n_pass++;
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clock);
            if (stall !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL mul_stall_c1_32: got %0d bad cycles expected 0", bad);
        else n_pass++;
        @(negedge clock);
        check_result("mul_7x6", (done === 1'b1) ? 33 : -1);
        n_total++;
        if (lo !== 32'd42 || hi !== 32'd0) $display("FAIL mul_7x6_const: got %h_%h expected 0_2a", hi, lo);
        else n_pass++;
    endtask

    task automatic run_op(input string name, input logic [3:0] r_op,
                          input logic [31:0] r_a, input logic [31:0] r_b);
        logic s0;
        int   cyc;
        @(negedge clock);
        model(r_op, r_a, r_b);
        start_op(r_op, r_a, r_b, s0);
        wait_done(cyc);
        check_result(name, cyc);
    endtask

    task automatic test_div_zero();
        run_op("div_100_7", 4'b1100, 32'd100, 32'd7);
        n_total++;
        if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL div_100_7_const: got q=%0d r=%0d expected 14 2", lo, hi);
        else n_pass++;
        run_op("div_5_0", 4'b1100, 32'd5, 32'd0);
    endtask

    task automatic test_flush();
        logic s0;
        @(negedge clock);
        start_op(4'b1000, 32'd3, 32'd4, s0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0)
            $display("FAIL flush_idle: got busy=%b done=%b stall=%b expected 0 0 0", busy, done, stall);
        else n_pass++;
        check_quiet("flush", 40);
        n_total++;
        if (hi !== exp_hi || lo !== exp_lo || dz !== exp_dz)
            $display("FAIL flush_hold: got %h_%h dz=%b expected %h_%h dz=%b", hi, lo, dz, exp_hi, exp_lo, exp_dz);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic s0;
        @(negedge clock);
        start_op(4'b1100, 32'd1000, 32'd3, s0);
        repeat (12) @(posedge clock);
        @(negedge clock);
        reset_0 = 1'b0;
        #1;
        n_total++;
        if ({hi, lo, dz, done, busy, stall} !== 68'd0)
            $display("FAIL reset_mid: got hi=%h lo=%h dz=%b done=%b busy=%b stall=%b expected all 0",
                     hi, lo, dz, done, busy, stall);
        else n_pass++;
        @(negedge clock);
        reset_0 = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        exp_dz = 1'b0;
        check_quiet("reset_release", 40);
    endtask

    task automatic test_back_to_back();
        logic s0;
        int   cyc;
        run_op("b2b_mul_2x3", 4'b1000, 32'd2, 32'd3);
        model(4'b1100, 32'd9, 32'd2);
        start_op(4'b1100, 32'd9, 32'd2, s0);
        n_total++;
        if (s0 !== 1'b1) $display("FAIL b2b_stall_done: got %b expected 1", s0);
        else n_pass++;
        wait_done(cyc);
        check_result("b2b_div_9_2", cyc);
    endtask

    task automatic test_invalid_op();
        @(negedge clock);
        @(negedge clock);
        start = 1'b1;
        op    = 4'b0101;
        a     = 32'd11;
        b     = 32'd13;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL invalid_stall: got %b expected 0", stall);
        else n_pass++;
        check_quiet("invalid_op", 5);
        start = 1'b0;
        op    = 4'd0;
        n_total++;
        if (hi !== exp_hi || lo !== exp_lo)
            $display("FAIL invalid_hold: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        for (int i = 0; i < 16; i++) begin
            r_op = ($urandom_range(0, 1) == 0) ? 4'b1000 : 4'b1100;
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = $urandom_range(1, 9);
                2: r_a = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), r_op, r_a, r_b);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_0 = 1'b0;
        start   = 1'b0;
        op      = 4'd0;
        a       = 32'd0;
        b       = 32'd0;
        flush   = 1'b0;
        test_reset();
        test_mul_basic();
        run_op("mul_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_invalid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
